// File: rtl/zsdram_port_scheduler.sv
// rtl/zsdram_port_scheduler.sv - two-port round-robin SDRAM access scheduler with auto-refresh insertion
module zsdram_port_scheduler #(
  parameter int unsigned REF_PERIOD = 1040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        iA_Req,
  input  logic [23:0] iA_Addr,
  output logic        oA_Ack,
  output logic        oA_Valid,
  output logic [15:0] oA_Data,
  input  logic        iB_Req,
  input  logic [23:0] iB_Addr,
  input  logic [15:0] iB_Data,
  output logic        oB_Ack,
  output logic        oB_Done,
  output logic [1:0]  oCall,
  output logic        oRef,
  output logic [23:0] oAddr,
  output logic [15:0] oWData,
  input  logic [15:0] iRData,
  input  logic [1:0]  iDone,
  input  logic        iRef_Done,
  output logic        oBusy,
  output logic        oRef_Ovf
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_REFRESH,
    ST_DONE
  } state_t;

  localparam logic [15:0] REF_LOAD = 16'(REF_PERIOD - 1);

  state_t      state;
  logic [15:0] ref_cnt;
  logic [1:0]  ref_pend;
  logic        last_b;
  logic        ref_expire;
  logic        ref_served;

  assign ref_expire = (ref_cnt == 16'd0);
  assign ref_served = (state == ST_REFRESH) && iRef_Done;
  assign oBusy      = (state != ST_IDLE);

  // Free-running refresh interval timer, reloads on every expiry regardless of en
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= REF_LOAD;
    end else if (ref_expire) begin
      ref_cnt <= REF_LOAD;
    end else begin
      ref_cnt <= ref_cnt - 16'd1;
    end
  end

  // Pending-refresh backlog: saturates at 3, an expiry at saturation latches the overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_pend <= 2'd0;
      oRef_Ovf <= 1'b0;
    end else begin
      if (ref_expire && (ref_pend == 2'd3)) begin
        oRef_Ovf <= 1'b1;
      end
      if (ref_expire && !ref_served) begin
        if (ref_pend != 2'd3) begin
          ref_pend <= ref_pend + 2'd1;
        end
      end else if (!ref_expire && ref_served) begin
        ref_pend <= ref_pend - 2'd1;
      end
    end
  end

  // Grant / access / refresh sequencer; all handshake outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      last_b   <= 1'b1;
      oA_Ack   <= 1'b0;
      oA_Valid <= 1'b0;
      oA_Data  <= 16'd0;
      oB_Ack   <= 1'b0;
      oB_Done  <= 1'b0;
      oCall    <= 2'b00;
      oRef     <= 1'b0;
      oAddr    <= 24'd0;
      oWData   <= 16'd0;
    end else begin
      oA_Ack   <= 1'b0;
      oB_Ack   <= 1'b0;
      oA_Valid <= 1'b0;
      oB_Done  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (en) begin
            if (ref_pend != 2'd0) begin
              oRef  <= 1'b1;
              state <= ST_REFRESH;
            end else if (iA_Req && (!iB_Req || last_b)) begin
              oAddr  <= iA_Addr;
              oA_Ack <= 1'b1;
              oCall  <= 2'b01;
              last_b <= 1'b0;
              state  <= ST_ACCESS;
            end else if (iB_Req) begin
              oAddr  <= iB_Addr;
              oWData <= iB_Data;
              oB_Ack <= 1'b1;
              oCall  <= 2'b10;
              last_b <= 1'b1;
              state  <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (oCall[0] && iDone[0]) begin
            oA_Data  <= iRData;
            oA_Valid <= 1'b1;
            oCall    <= 2'b00;
            state    <= ST_DONE;
          end else if (oCall[1] && iDone[1]) begin
            oB_Done <= 1'b1;
            oCall   <= 2'b00;
            state   <= ST_DONE;
          end
        end
        ST_REFRESH: begin
          if (iRef_Done) begin
            oRef  <= 1'b0;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/zsdram_port_scheduler.md
# zsdram_port_scheduler

Two-port SDRAM access scheduler with built-in auto-refresh timing. It sits between the display frame-buffer reader (port A) and the detector data writer (port B) on one side, and the word-level SDRAM core on the other. It grants single-word accesses round-robin and inserts auto-refresh requests at a fixed interval with priority over both ports.

## Interface
Parameters:
- REF_PERIOD, 1040: clocks between refresh requests (7.8 us at 133 MHz); legal range 16..65535.

Ports:
- clk  in  1  133 MHz system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  enables new grants; in-flight operations always complete.
- iA_Req  in  1  port A read request; requester holds it, with iA_Addr, until oA_Ack.
- iA_Addr  in  24  port A address: bank(2), row(13), column(9).
- oA_Ack  out  1  one-cycle pulse; request and address captured.
- oA_Valid  out  1  one-cycle pulse; oA_Data valid.
- oA_Data  out  16  read data; holds its value until the next port A read completes.
- iB_Req  in  1  port B write request; held, with iB_Addr and iB_Data, until oB_Ack.
- iB_Addr  in  24  port B address.
- iB_Data  in  16  port B write data.
- oB_Ack  out  1  one-cycle pulse; request captured.
- oB_Done  out  1  one-cycle pulse; write completed.
- oCall  out  2  to core: [1] write, [0] read; one-hot or zero.
- oRef  out  1  to core: auto-refresh request.
- oAddr  out  24  to core: captured address.
- oWData  out  16  to core: captured write data.
- iRData  in  16  from core: read data.
- iDone  in  2  from core: [1] write done, [0] read done.
- iRef_Done  in  1  from core: refresh done.
- oBusy  out  1  high in every state except IDLE.
- oRef_Ovf  out  1  sticky flag: refresh backlog overflowed.

## Operation
- States: IDLE, ACCESS, REFRESH, DONE.
- Refresh timer: a 16-bit down-counter runs whenever rst is low, independent of en.
  - It loads REF_PERIOD-1 and counts down.
  - On reaching 0 it reloads and increments ref_pend, a 2-bit counter saturating at 3.
  - An expiry while ref_pend==3 sets oRef_Ovf.
  - If an expiry and a refresh completion happen in the same cycle, ref_pend is unchanged.
- IDLE: grants only when en=1. Priority order:
  1. ref_pend!=0: go to REFRESH and set oRef=1.
  2. Only one port requesting: grant that port.
  3. Both ports requesting: grant the port not served last. last_served resets to B, so A wins first.
- On a port grant:
  - Capture the address, and the data for port B, into oAddr/oWData.
  - Pulse the matching Ack.
  - Set oCall to 2'b01 for A or 2'b10 for B.
  - Update last_served and go to ACCESS.
- ACCESS: hold oCall, oAddr and oWData stable until the matching iDone bit is high.
  - Then drop oCall to 0 and go to DONE.
  - For a read, capture iRData into oA_Data and pulse oA_Valid.
  - For a write, pulse oB_Done.
  - The non-matching iDone bit is ignored.
- REFRESH: hold oRef until iRef_Done. Then drop oRef, decrement ref_pend and go to DONE.
- DONE: one cycle with oCall=0 and oRef=0, so the core can clear its done flag. Then go to IDLE.
- iDone and iRef_Done are ignored in IDLE and DONE.
- en low does not abort an operation in ACCESS or REFRESH. It only blocks grants in IDLE.

## Timing
- Reset values:
  - All outputs 0, including oA_Data, oAddr, oWData and oRef_Ovf.
  - State IDLE, ref_pend 0, timer loaded with REF_PERIOD-1, last_served = B.
- Reset mid-operation: the operation is abandoned immediately. The next cycle shows oCall=0 and oRef=0; no Ack, Valid or Done pulse is generated.
- Request sampled high at edge k in IDLE: after edge k, Ack=1, oCall is set and oBusy=1.
- Ack lasts exactly one cycle. The requester may drop or change its request in the cycle after Ack.
- iDone sampled high at edge m: after edge m, oCall=0, Valid/Done=1 and the state is DONE.
- After edge m+1: Valid/Done=0, state IDLE, oBusy=0. The earliest next grant is at edge m+2.
- Minimum service time: 4 clocks from request to the next possible grant, with a core that returns iDone 1 clock after oCall.
- First refresh: ref_pend becomes 1 REF_PERIOD clocks after reset deasserts.

## Test plan
- Single read: iA_Addr=24'h012345, core returns 16'hBEEF 3 clocks after oCall=01 -> oA_Ack 1 clock after the request, oA_Valid with oA_Data=16'hBEEF, then oBusy low 1 clock later.
- Single write: iB_Addr=24'hABCDE, iB_Data=16'h5A5A -> oCall=10 with oAddr=24'hABCDE and oWData=16'h5A5A held until iDone[1], then oB_Done pulses once.
- Contention: iA_Req and iB_Req held high for 6 grants -> grant order A, B, A, B, A, B; no two grants closer than 2 clocks after a done.
- Refresh priority: REF_PERIOD=16, both ports requesting when the timer expires -> the next IDLE grant is REFRESH (oRef=1); ports resume after iRef_Done.
- Refresh overflow: REF_PERIOD=16, iRef_Done never asserted, 5 expiries -> ref_pend saturates at 3 and oRef_Ovf=1 and stays 1 until rst.
- Abort and disable: rst pulsed while in ACCESS -> no Valid or Done, all outputs 0 next cycle. en=0 with iA_Req held -> no oA_Ack until en=1.
